// File: rtl/apb_cmd_pkg.sv
// Purpose : shared types for the APB command master (FSM states, command record).
// Latency : n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   CMD_ADDR_W / CMD_DATA_W : bus widths the command record is sized for.
//                             The top-level ADDR_W/DATA_W must not exceed them.
//   state_t                 : APB transfer FSM states.
//   cmd_t                   : one queued register-access command.
package apb_cmd_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/cmd_fifo.sv
// Purpose : generic synchronous FIFO with full/empty flags, head entry visible combinationally.
// Latency : an entry pushed at edge N is visible on o_head_dat after edge N.
// Backpressure: pushes while full and pops while empty are ignored; flags come from a registered count.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset (flushes pointers/count)
//   i_push, i_push_dat    write request and data
//   i_pop                 remove head entry
//   o_head_dat            current head entry (valid when !o_empty)
//   o_full, o_empty       occupancy flags
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_head_dat = r_mem[r_rd_ptr];

  // Storage needs no reset: nothing reads it until the count says it is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// Purpose : queue register-access commands and issue each as a two-phase APB transfer to the bridge.
// Latency : accept at E0 -> SETUP after E1 -> ACCESS after E2 -> rsp_valid after the edge that samples apb_ready.
// Backpressure: cmd_ready drops when the FIFO is full; no new transfer starts while a response is held.
//
// Ports:
//   i2c_clk, i2c_rstn          clock shared with the bridge, async active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_write/cmd_addr/cmd_wdata command fields
//   rsp_valid/rsp_ready        response handshake; rsp_rdata/rsp_slverr/rsp_timeout results
//   apb_addr/apb_wdata/apb_write/apb_sel/apb_enable   APB request to the bridge
//   apb_rdata/apb_ready/apb_slverr                    APB completion from the bridge
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_W     = CMD_ADDR_W,
  parameter int DATA_W     = CMD_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic              i2c_clk,
  input  logic              i2c_rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] apb_addr,
  output logic [DATA_W-1:0] apb_wdata,
  output logic              apb_write,
  output logic              apb_sel,
  output logic              apb_enable,
  input  logic [DATA_W-1:0] apb_rdata,
  input  logic              apb_ready,
  input  logic              apb_slverr
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_apb_addr,  w_apb_addr_nxt;
  logic [DATA_W-1:0] r_apb_wdata, w_apb_wdata_nxt;
  logic              r_apb_write, w_apb_write_nxt;
  logic              r_apb_sel,   w_apb_sel_nxt;
  logic              r_apb_en,    w_apb_en_nxt;
  logic              r_rsp_vld,   w_rsp_vld_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err,   w_rsp_err_nxt;
  logic              r_rsp_tmo,   w_rsp_tmo_nxt;
  logic [TW-1:0]     r_tmo_cnt,   w_tmo_cnt_nxt;

  cmd_t              w_push_cmd;
  cmd_t              w_head_cmd;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;

  assign w_push_cmd.write = cmd_write;
  assign w_push_cmd.addr  = CMD_ADDR_W'(cmd_addr);
  assign w_push_cmd.wdata = CMD_DATA_W'(cmd_wdata);

  // cmd_ready depends only on the registered FIFO count, never on cmd_valid.
  assign cmd_ready = !w_fifo_full;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .i_clk      (i2c_clk),
    .i_rst_n    (i2c_rstn),
    .i_push     (cmd_valid),
    .i_push_dat (w_push_cmd),
    .i_pop      (w_pop),
    .o_head_dat (w_head_cmd),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  always_ff @(posedge i2c_clk or negedge i2c_rstn) begin
    if (!i2c_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_apb_addr_nxt  = r_apb_addr;
    w_apb_wdata_nxt = r_apb_wdata;
    w_apb_write_nxt = r_apb_write;
    w_apb_sel_nxt   = r_apb_sel;
    w_apb_en_nxt    = r_apb_en;
    w_rsp_vld_nxt   = r_rsp_vld;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_tmo_nxt   = r_rsp_tmo;
    w_tmo_cnt_nxt   = r_tmo_cnt;

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && !r_rsp_vld) begin
          w_pop           = 1'b1;
          w_apb_addr_nxt  = ADDR_W'(w_head_cmd.addr);
          w_apb_wdata_nxt = DATA_W'(w_head_cmd.wdata);
          w_apb_write_nxt = w_head_cmd.write;
          w_apb_sel_nxt   = 1'b1;
          w_apb_en_nxt    = 1'b0;
          w_state_nxt     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        w_apb_en_nxt  = 1'b1;
        w_tmo_cnt_nxt = '0;
        w_state_nxt   = ST_ACCESS;
      end

      ST_ACCESS: begin
        // r_tmo_cnt holds the number of earlier ACCESS cycles without ready,
        // so TIMEOUT-1 here means this is the last permitted cycle.
        if (r_tmo_cnt != TW'(TIMEOUT)) begin
          w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
        end
        if (apb_ready) begin
          w_rsp_vld_nxt   = 1'b1;
          w_rsp_rdata_nxt = r_apb_write ? '0 : apb_rdata;
          w_rsp_err_nxt   = apb_slverr;
          w_rsp_tmo_nxt   = 1'b0;
          w_apb_sel_nxt   = 1'b0;
          w_apb_en_nxt    = 1'b0;
          w_state_nxt     = ST_RESP;
        end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
          w_rsp_vld_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_tmo_nxt   = 1'b1;
          w_apb_sel_nxt   = 1'b0;
          w_apb_en_nxt    = 1'b0;
          w_state_nxt     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_vld_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i2c_clk or negedge i2c_rstn) begin
    if (!i2c_rstn) begin
      r_apb_addr  <= '0;
      r_apb_wdata <= '0;
      r_apb_write <= 1'b0;
      r_apb_sel   <= 1'b0;
      r_apb_en    <= 1'b0;
      r_rsp_vld   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_tmo   <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      r_apb_addr  <= w_apb_addr_nxt;
      r_apb_wdata <= w_apb_wdata_nxt;
      r_apb_write <= w_apb_write_nxt;
      r_apb_sel   <= w_apb_sel_nxt;
      r_apb_en    <= w_apb_en_nxt;
      r_rsp_vld   <= w_rsp_vld_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_tmo   <= w_rsp_tmo_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
    end
  end

  assign apb_addr    = r_apb_addr;
  assign apb_wdata   = r_apb_wdata;
  assign apb_write   = r_apb_write;
  assign apb_sel     = r_apb_sel;
  assign apb_enable  = r_apb_en;
  assign rsp_valid   = r_rsp_vld;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_slverr  = r_rsp_err;
  assign rsp_timeout = r_rsp_tmo;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Purpose : directed self-checking bench for apb_cmd_master with a small bridge model.
// Latency : n/a.
// Backpressure: bench drives rsp_ready directly to exercise response stalls.
module tb_apb_cmd_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          i2c_clk;
  logic          i2c_rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic [AW-1:0] apb_addr;
  logic [DW-1:0] apb_wdata;
  logic          apb_write;
  logic          apb_sel;
  logic          apb_enable;
  logic [DW-1:0] apb_rdata;
  logic          apb_ready;
  logic          apb_slverr;

  // Bridge model: ready after wait_n ACCESS cycles unless hung; read data is
  // rd_base XOR address so every read has a distinct, predictable value.
  logic          hang;
  int            wait_n;
  logic [DW-1:0] rd_base;
  logic          bridge_err;
  int            acc_cnt = 0;

  assign apb_ready  = !hang && (acc_cnt >= wait_n);
  assign apb_rdata  = rd_base ^ apb_addr;
  assign apb_slverr = bridge_err;

  always @(posedge i2c_clk) begin
    acc_cnt <= (apb_sel && apb_enable) ? acc_cnt + 1 : 0;
  end

  apb_cmd_master #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (4),
    .TIMEOUT    (TMO)
  ) dut (
    .i2c_clk     (i2c_clk),
    .i2c_rstn    (i2c_rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .apb_addr    (apb_addr),
    .apb_wdata   (apb_wdata),
    .apb_write   (apb_write),
    .apb_sel     (apb_sel),
    .apb_enable  (apb_enable),
    .apb_rdata   (apb_rdata),
    .apb_ready   (apb_ready),
    .apb_slverr  (apb_slverr)
  );

  initial i2c_clk = 1'b0;
  always #5 i2c_clk = ~i2c_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i2c_clk);
    #1;
  endtask

  typedef struct {
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    int            wait_n;
    logic          hang;
    logic          err;
    logic [31:0]   base;
    logic [31:0]   exp_rdata;
    logic          exp_slverr;
    logic          exp_tmo;
    int            exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    int   m;
    logic ph_ok;
    logic stab_ok;
    logic seen;

    // wr, addr, wdata, wait, hang, err, base, exp_rdata, exp_err, exp_tmo, latency
    vecs[0] = '{1'b1, 32'h04, 32'hA5,       0, 1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 3};
    vecs[1] = '{1'b0, 32'h08, 32'h0,        5, 1'b0, 1'b0, 32'h34,  32'h3C,  1'b0, 1'b0, 8};
    vecs[2] = '{1'b0, 32'h0C, 32'h0,        0, 1'b0, 1'b1, 32'h100, 32'h10C, 1'b1, 1'b0, 3};
    vecs[3] = '{1'b0, 32'h40, 32'h0,        0, 1'b1, 1'b0, 32'h55,  32'h0,   1'b1, 1'b1, 18};
    vecs[4] = '{1'b1, 32'h44, 32'hDEADBEEF, 2, 1'b0, 1'b1, 32'h77,  32'h0,   1'b1, 1'b0, 5};

    cmd_valid  = 1'b0;
    cmd_write  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b0;
    hang       = 1'b0;
    wait_n     = 0;
    rd_base    = '0;
    bridge_err = 1'b0;
    i2c_rstn   = 1'b0;

    repeat (3) tick();
    i2c_rstn = 1'b1;
    tick();
    chk("rst_apb_ctl",   {apb_sel, apb_enable, apb_write}, 0);
    chk("rst_apb_addr",  apb_addr, 0);
    chk("rst_apb_wdata", apb_wdata, 0);
    chk("rst_rsp_flags", {rsp_valid, rsp_slverr, rsp_timeout}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    // Single-transfer vectors: phase sequence, stability, latency, results.
    for (int v = 0; v < 5; v++) begin
      hang       = vecs[v].hang;
      wait_n     = vecs[v].wait_n;
      bridge_err = vecs[v].err;
      rd_base    = vecs[v].base;
      cmd_valid  = 1'b1;
      cmd_write  = vecs[v].wr;
      cmd_addr   = vecs[v].addr;
      cmd_wdata  = vecs[v].wdata;
      tick();
      cmd_valid = 1'b0;
      n       = 0;
      ph_ok   = 1'b1;
      stab_ok = 1'b1;
      while (!rsp_valid && n <= 40) begin
        tick();
        n++;
        if (n == 1 && !(apb_sel && !apb_enable)) ph_ok = 1'b0;
        if (n == 2 && !(apb_sel && apb_enable))  ph_ok = 1'b0;
        if (n >= 2 && !rsp_valid) begin
          if (!(apb_sel && apb_enable && apb_addr == vecs[v].addr &&
                apb_write == vecs[v].wr && apb_wdata == vecs[v].wdata))
            stab_ok = 1'b0;
        end
      end
      chk($sformatf("v%0d_phases", v),  ph_ok, 1);
      chk($sformatf("v%0d_stable", v),  stab_ok, 1);
      chk($sformatf("v%0d_latency", v), n, vecs[v].exp_lat);
      chk($sformatf("v%0d_rdata", v),   rsp_rdata, vecs[v].exp_rdata);
      chk($sformatf("v%0d_slverr", v),  rsp_slverr, vecs[v].exp_slverr);
      chk($sformatf("v%0d_timeout", v), rsp_timeout, vecs[v].exp_tmo);
      chk($sformatf("v%0d_sel_drop", v), {apb_sel, apb_enable}, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_rsp_clear", v), rsp_valid, 0);
    end

    // Response backpressure: five reads with rsp_ready low fill the FIFO.
    hang       = 1'b0;
    wait_n     = 0;
    bridge_err = 1'b0;
    rd_base    = 32'hA000_0000;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_push%0d_ready", i), cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h10 + 32'(4 * i);
      cmd_wdata = '0;
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_full_ready", cmd_ready, 0);
    chk("bp_rsp_held",   rsp_valid, 1);

    // Offer one more command while full; it must be dropped.
    cmd_valid = 1'b1;
    cmd_addr  = 32'h99;
    seen      = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cmd_valid = 1'b0;
      if (apb_sel) seen = 1'b1;
    end
    chk("bp_no_second_sel", seen, 0);

    for (int k = 0; k < 5; k++) begin
      m = 0;
      while (!rsp_valid && m < 50) begin
        tick();
        m++;
      end
      chk($sformatf("bp_rsp%0d_valid", k),  rsp_valid, 1);
      chk($sformatf("bp_rsp%0d_rdata", k),  rsp_rdata, 32'hA000_0010 + 32'(4 * k));
      chk($sformatf("bp_rsp%0d_slverr", k), rsp_slverr, 0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      if (k == 0) begin
        chk("pop_while_full_ready", cmd_ready, 0);
        tick();
        chk("after_pop_ready", cmd_ready, 1);
        chk("after_pop_sel",   apb_sel, 1);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid || apb_sel) seen = 1'b1;
    end
    chk("bp_dropped_cmd_absent", seen, 0);

    // Reset during ACCESS with two commands still queued.
    hang = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h50 + 32'(4 * i);
      cmd_wdata = 32'h1234_0000 + 32'(i);
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    chk("pre_rst_access", {apb_sel, apb_enable}, 2'b11);
    chk("pre_rst_full",   cmd_ready, 1);
    i2c_rstn = 1'b0;
    #1;
    chk("rst_mid_apb_ctl",  {apb_sel, apb_enable, apb_write}, 0);
    chk("rst_mid_apb_addr", apb_addr, 0);
    chk("rst_mid_rsp",      {rsp_valid, rsp_slverr, rsp_timeout}, 0);
    chk("rst_mid_ready",    cmd_ready, 1);
    tick();
    tick();
    i2c_rstn = 1'b1;
    hang     = 1'b0;
    seen     = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid || apb_sel) seen = 1'b1;
    end
    chk("rst_flushed_no_activity", seen, 0);
    chk("rst_after_ready",         cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
